// File: rtl/hist_acq_scheduler_if.sv
// Bus between the TDC front end, the acquisition scheduler and the histogram builder.
// Ports: tdc_valid/tdc_data (TDC codes in), hb_* (builder clear/write strobes),
//        peak_rd_* (peak-result readout strobe and pixel index).
//        master = scheduler side, slave = front end / builder side.
interface hist_acq_scheduler_if #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM         = 6,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int ACQ_NUM           = 2
);
    localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int RD_W  = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;

    logic             tdc_valid;
    logic [NP-1:0]    tdc_data;
    logic             hb_clear;
    logic             hb_wr_en;
    logic [NP-1:0]    hb_data;
    logic [PIX_W-1:0] hb_pix_idx;
    logic [ACQ_W-1:0] hb_acq_idx;
    logic             peak_rd_en;
    logic [RD_W-1:0]  peak_rd_idx;

    modport master (
        input  tdc_valid,
        input  tdc_data,
        output hb_clear,
        output hb_wr_en,
        output hb_data,
        output hb_pix_idx,
        output hb_acq_idx,
        output peak_rd_en,
        output peak_rd_idx
    );

    modport slave (
        output tdc_valid,
        output tdc_data,
        input  hb_clear,
        input  hb_wr_en,
        input  hb_data,
        input  hb_pix_idx,
        input  hb_acq_idx,
        input  peak_rd_en,
        input  peak_rd_idx
    );
endinterface

// File: rtl/hist_acq_scheduler.sv
// Frame sequencer for the dToF histogram builder: clear, tagged TDC writes,
// pipeline drain, then peak readout over the RAM pixels.
// Ports: clk, res (async, active-high), start, abort (host control);
//        bus (master modport: TDC in, builder/readout strobes out);
//        busy, done (frame status), dropped (sticky: code seen outside ACQ).
module hist_acq_scheduler #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM         = 6,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int ACQ_NUM           = 2,
    parameter int DRAIN_CYCLES      = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic                  abort,
    hist_acq_scheduler_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  dropped
);
    localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int RD_W  = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
    localparam int DR_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACQ,
        S_DRAIN,
        S_READOUT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [ACQ_W-1:0] acq_cnt_q, acq_cnt_d;
    logic [DR_W-1:0]  drain_cnt_q, drain_cnt_d;

    logic             clear_q, clear_d;
    logic             wr_q, wr_d;
    logic [NP-1:0]    data_q, data_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
    logic [ACQ_W-1:0] acq_idx_q, acq_idx_d;
    logic             rd_en_q, rd_en_d;
    logic [RD_W-1:0]  rd_idx_q, rd_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dropped_q, dropped_d;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= '0;
            acq_cnt_q   <= '0;
            drain_cnt_q <= '0;
            clear_q     <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            pix_idx_q   <= '0;
            acq_idx_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            acq_cnt_q   <= acq_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            clear_q     <= clear_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            pix_idx_q   <= pix_idx_d;
            acq_idx_q   <= acq_idx_d;
            rd_en_q     <= rd_en_d;
            rd_idx_q    <= rd_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dropped_q   <= dropped_d;
        end
    end

    // Next state and next output values; every output is the registered
    // copy of these, so strobes line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        acq_cnt_d   = acq_cnt_q;
        drain_cnt_d = drain_cnt_q;
        clear_d     = 1'b0;
        wr_d        = 1'b0;
        data_d      = data_q;
        pix_idx_d   = pix_idx_q;
        acq_idx_d   = acq_idx_q;
        rd_en_d     = 1'b0;
        rd_idx_d    = rd_idx_q;
        done_d      = 1'b0;
        dropped_d   = dropped_q;

        if (abort) begin
            state_d     = S_IDLE;
            pix_cnt_d   = '0;
            acq_cnt_d   = '0;
            drain_cnt_d = '0;
            pix_idx_d   = '0;
            acq_idx_d   = '0;
            rd_idx_d    = '0;
        end else begin
            if (bus.tdc_valid && (state_q != S_ACQ)) begin
                dropped_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_CLEAR;
                        clear_d   = 1'b1;
                        pix_cnt_d = '0;
                        acq_cnt_d = '0;
                        // A code arriving with the start is still a drop.
                        dropped_d = bus.tdc_valid;
                    end
                end
                S_CLEAR: begin
                    state_d = S_ACQ;
                end
                S_ACQ: begin
                    if (bus.tdc_valid) begin
                        wr_d      = 1'b1;
                        data_d    = bus.tdc_data;
                        pix_idx_d = pix_cnt_q;
                        acq_idx_d = acq_cnt_q;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            if (acq_cnt_q == ACQ_LAST) begin
                                acq_cnt_d   = '0;
                                drain_cnt_d = '0;
                                state_d     = S_DRAIN;
                            end else begin
                                acq_cnt_d = acq_cnt_q + 1'b1;
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle carries the final write, so the
                    // strobe-free gap is DRAIN_CYCLES after it.
                    if (drain_cnt_q == DR_LAST) begin
                        drain_cnt_d = '0;
                        state_d     = S_READOUT;
                        rd_en_d     = 1'b1;
                        rd_idx_d    = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                S_READOUT: begin
                    if (rd_idx_q == RD_LAST) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        rd_idx_d = '0;
                    end else begin
                        rd_en_d  = 1'b1;
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // busy drops together with the done pulse.
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    assign bus.hb_clear    = clear_q;
    assign bus.hb_wr_en    = wr_q;
    assign bus.hb_data     = data_q;
    assign bus.hb_pix_idx  = pix_idx_q;
    assign bus.hb_acq_idx  = acq_idx_q;
    assign bus.peak_rd_en  = rd_en_q;
    assign bus.peak_rd_idx = rd_idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign dropped         = dropped_q;
endmodule
